seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder that sums two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a registered carry flop between slices. Operands enter and results leave over valid/ready handshakes, so the block drops into any streaming datapath as the area-cheap successor to the fixed 4-bit combinational adder. It reports carry-out and signed overflow, and can optionally accumulate into its own result.

---
 rtl/seq_chunk_adder_if.sv | 35 +++
 rtl/seq_chunk_adder.sv | 103 ++++++++++
 tb/tb_seq_chunk_adder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Handshake bundle for seq_chunk_adder: operand side and result side.
// acc_sel exists only when SEQ_ADDER_ACCUM_EN is defined.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp_1;
  logic [WIDTH-1:0] inp_2;
  logic             carry_in;
`ifdef SEQ_ADDER_ACCUM_EN
  logic             acc_sel;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
`ifdef SEQ_ADDER_ACCUM_EN
    output acc_sel,
`endif
    output in_valid, inp_1, inp_2, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
`ifdef SEQ_ADDER_ACCUM_EN
    input  acc_sel,
`endif
    input  in_valid, inp_1, inp_2, carry_in, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock, carry kept in a flop between slices.
// Optional accumulate mode (acc_sel) under macro SEQ_ADDER_ACCUM_EN.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, sum_q, b_sel;
  logic             c_q, carry_q, ovf_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_sl, b_sl, s_n;
  logic             c_n, last;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
    {c_n, s_n} = {1'b0, a_sl} + {1'b0, b_sl}
               + {{CHUNK{1'b0}}, c_q};
    last = (idx == IW'(NCHUNK - 1));
  end

  // Accumulate reuses the live sum register as operand B.
  always_comb begin
`ifdef SEQ_ADDER_ACCUM_EN
    b_sel = bus.acc_sel ? sum_q : bus.inp_2;
`else
    b_sel = bus.inp_2;
`endif
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_n = ADD;
      ADD:  if (last) state_n = DONE;
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.inp_1;
            b_q <= b_sel;
            c_q <= bus.carry_in;
            idx <= '0;
          end
        end
        ADD: begin
          c_q <= c_n;
          idx <= idx + IW'(1);
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) sum_q[i*CHUNK +: CHUNK] <= s_n;
          end
          if (last) begin
            carry_q <= c_n;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                    && (s_n[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
// Accumulate cases run only when SEQ_ADDER_ACCUM_EN is defined.
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) bus ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];
  logic [15:0] model_sum = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] a,
                          input logic [15:0] b,
                          input logic cin);
    logic [16:0] r;
    logic ovf;
    r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    ovf = (a[15] == b[15]) && (r[15] != a[15]);
    model_sum = r[15:0];
    exp_q.push_back({ovf, r[16], r[15:0]});
  endtask

  task automatic set_acc(input logic v);
`ifdef SEQ_ADDER_ACCUM_EN
    bus.acc_sel = v;
`else
    if (v) $display("note: acc_sel requested without accumulate build");
`endif
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic acc);
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.inp_1 = a;
    bus.inp_2 = b;
    bus.carry_in = cin;
    set_acc(acc);
    push_exp(a, acc ? model_sum : b, cin);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.inp_1 = 16'($urandom);
    bus.inp_2 = 16'($urandom);
    bus.carry_in = 1'($urandom);
    set_acc(1'b0);
  endtask

  task automatic run_op(input string tag,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic acc, input int hold);
    int n;
    logic [17:0] e, snap;
    accept(a, b, cin, acc);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.out_valid && n < 20);
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_no_in_ready"}, 32'(bus.in_ready), 32'd0);
    snap = {bus.overflow, bus.carry, bus.sum};
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.inp_1 = 16'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_hold_res"}, 32'({bus.overflow, bus.carry, bus.sum}),
            32'(snap));
    end
    bus.in_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(bus.sum), 32'(e[15:0]));
      check({tag, "_carry"}, 32'(bus.carry), 32'(e[16]));
      check({tag, "_ovf"}, 32'(bus.overflow), 32'(e[17]));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_release"}, 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_sum"}, 32'(bus.sum), 32'd0);
    check({tag, "_carry"}, 32'(bus.carry), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_sum = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.inp_1 = '0;
    bus.inp_2 = '0;
    bus.carry_in = 1'b0;
    bus.out_ready = 1'b0;
    set_acc(1'b0);
    #1;
    check_reset_outs("por");
    do_reset();

    run_op("basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    run_op("bp", 16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 5);
    run_op("post_bp", 16'h0102, 16'h0304, 1'b0, 1'b0, 0);

    // Reset asserted mid-cycle while a result is held.
    accept(16'h4321, 16'h1234, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    exp_q.delete();
    model_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Abort during ADD: no result may ever appear.
    accept(16'h5555, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_sum = '0;
    #1;
    check("abort_sum", 32'(bus.sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end
    check("abort_sum_after", 32'(bus.sum), 32'd0);

`ifdef SEQ_ADDER_ACCUM_EN
    run_op("acc1", 16'h0005, 16'h7777, 1'b0, 1'b1, 0);
    check("acc1_val", 32'(model_sum), 32'h0005);
    run_op("acc2", 16'h0005, 16'h1234, 1'b0, 1'b1, 0);
    run_op("acc3", 16'h0005, 16'hFFFF, 1'b0, 1'b1, 0);
    check("acc3_val", 32'(bus.sum), 32'h000F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
